fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, minimum 2.
REQ-002 SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_f_done, input, 1 bit: fetch presents a valid instruction this cycle.
REQ-005 SHALL have port in_f_insnbits, input, `INSNBITS_SIZE bits: instruction bits from fetch.
REQ-006 SHALL have port in_f_pc, input, `GPR_SIZE bits: PC of the fetched instruction.
REQ-007 SHALL have port in_rob_mispredict, input, 1 bit: flush request.
REQ-008 SHALL have port in_d_ready, input, 1 bit: decode accepts an entry this cycle.
REQ-009 SHALL have port out_f_full, output, 1 bit: queue full; fetch holds its PC.
REQ-010 SHALL have port out_d_valid, output, 1 bit: head entry valid for decode.
REQ-011 SHALL have port out_d_insnbits, output, `INSNBITS_SIZE bits: head instruction bits.
REQ-012 SHALL have port out_d_pc, output, `GPR_SIZE bits: head PC.
REQ-013 SHALL have port out_count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 SHALL be a circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits wide, that wrap from DEPTH-1 to 0, plus a count register.
REQ-015 SHALL push at the clock edge when in_f_done=1, out_f_full=0, the state is RUN, and in_rob_mispredict=0.
REQ-016 SHALL pop at the clock edge when out_d_valid=1 and in_d_ready=1.
REQ-017 SHALL drive out_f_full = (count==DEPTH) combinationally; when the queue is full, a push is refused even if a pop occurs in the same cycle.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop; the entry order SHALL be strictly FIFO.
REQ-019 SHALL drive out_d_valid = (count!=0) & ~in_rob_mispredict, with out_d_insnbits/out_d_pc taken from entry[rd_ptr]; when out_d_valid=0, both data outputs SHALL be 0.
REQ-020 SHALL give a minimum latency of 1 cycle from push to out_d_valid when the bypass of REQ-027 is compiled out.
REQ-021 SHALL, when in_rob_mispredict=1, clear count, rd_ptr and wr_ptr at that edge, discard any same-cycle push and pop, and enter RUN.
REQ-022 SHALL implement a state machine with two states, RUN and HALTED.
  - RUN -> HALTED: a popped entry equals INSNBITS_HLT; the queue is cleared at the same edge.
  - HALTED -> RUN: only on in_rob_mispredict or reset.
  - In HALTED: pushes are dropped, out_d_valid=0, out_f_full=0.
REQ-023 SHALL treat in_f_done=1 with in_f_insnbits=0 as a normal push, with no filtering.

Reset
REQ-024 SHALL, while in_rst=1, asynchronously force the state to RUN, count=0, rd_ptr=0, wr_ptr=0, out_d_valid=0, out_d_insnbits=0, out_d_pc=0, out_f_full=0 and out_count=0.
REQ-025 SHALL accept its first push on the first rising edge after in_rst deasserts.
REQ-026 SHALL NOT be required to clear entry storage on reset.

Configuration
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined, pass fetch data straight through when count==0, state RUN, in_f_done=1 and in_rob_mispredict=0.
  - out_d_valid=1 and out_d_* = in_f_* combinationally, giving 0-cycle latency.
  - If in_d_ready=1 the entry is not stored; otherwise it is pushed normally.
  - An INSNBITS_HLT consumed through the bypass SHALL enter HALTED.
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, contain no bypass path; out_d_* SHALL depend on registered state and in_rob_mispredict only.

Structure
REQ-029 SHALL take `INSNBITS_SIZE, `GPR_SIZE and INSNBITS_HLT from the shared definitions; the fq_state_t enum (FQ_RUN, FQ_HALTED) SHALL live in the shared package.
REQ-030 SHALL place storage in one sub-module, fq_storage (DEPTH x {pc, insnbits}, one write port, one combinational read port); pointer, count and FSM logic SHALL stay in fetch_queue.

Verification (DEPTH=4, bypass off unless stated)
REQ-031 SHALL cover fill and drain: push 5 consecutive PCs 0x100..0x110 with in_d_ready=0 -> out_f_full=1 after 4 pushes and 0x110 refused; then in_d_ready=1 -> PCs 0x100..0x10C emerge in order, one per cycle, and out_count reaches 0.
REQ-032 SHALL cover wrap-around: sustain push and pop every cycle for 10 cycles -> out_count stays at 1 and the PC sequence is unbroken across pointer wrap.
REQ-033 SHALL cover flush: with 3 entries queued, assert in_rob_mispredict together with a push of 0x200 -> out_d_valid=0 in that cycle, out_count=0 next cycle, and 0x200 is absent.
REQ-034 SHALL cover halt: queue {ADD@0x100, HLT@0x104, ADD@0x108} -> after HLT is popped, state HALTED, out_count=0, out_d_valid stays 0 despite further pushes until in_rob_mispredict.
REQ-035 SHALL cover bypass: with FETCH_QUEUE_BYPASS_EN defined, an empty queue, in_f_done=1 at PC 0x300 and in_d_ready=1 -> out_d_pc=0x300 in the same cycle and out_count stays 0.
REQ-036 SHALL cover reset mid-operation: assert in_rst asynchronously between edges with 2 entries queued -> out_d_valid drops to 0 immediately and out_count=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: instruction/GPR widths, the HLT encoding
// and the queue state enum.
`ifndef INSNBITS_SIZE
`define INSNBITS_SIZE 32
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

package fetch_queue_pkg;

  typedef enum logic {
    FQ_RUN    = 1'b0,
    FQ_HALTED = 1'b1
  } fq_state_t;

  localparam logic [`INSNBITS_SIZE-1:0] INSNBITS_HLT = `INSNBITS_SIZE'(32'hD440_0000);

  function automatic logic is_hlt(input logic [`INSNBITS_SIZE-1:0] insn);
    return insn == INSNBITS_HLT;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH x WIDTH, one write port and one
// combinational read port. Contents are not reset.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch-to-decode instruction queue with flush and HLT-driven halt.
// Optional 0-cycle pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_f_done,
  input  logic [`INSNBITS_SIZE-1:0] in_f_insnbits,
  input  logic [`GPR_SIZE-1:0]      in_f_pc,
  input  logic                      in_rob_mispredict,
  input  logic                      in_d_ready,
  output logic                      out_f_full,
  output logic                      out_d_valid,
  output logic [`INSNBITS_SIZE-1:0] out_d_insnbits,
  output logic [`GPR_SIZE-1:0]      out_d_pc,
  output logic [$clog2(DEPTH):0]    out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = `GPR_SIZE + `INSNBITS_SIZE;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_state_t r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [ENT_W-1:0]          w_head;
  logic [`GPR_SIZE-1:0]      w_head_pc;
  logic [`INSNBITS_SIZE-1:0] w_head_insn;
  logic w_run, w_empty, w_full, w_q_valid, w_pop_q, w_pop_byp, w_push, w_halt;

  fq_storage #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_storage (
    .i_clk   (in_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_f_pc, in_f_insnbits}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign {w_head_pc, w_head_insn} = w_head;
  assign w_run     = (r_state == FQ_RUN);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_q_valid = ~w_empty & w_run & ~in_rob_mispredict;
  assign w_pop_q   = w_q_valid & in_d_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_byp;
  assign w_byp     = w_empty & w_run & in_f_done & ~in_rob_mispredict;
  assign w_pop_byp = w_byp & in_d_ready;
`else
  assign w_pop_byp = 1'b0;
`endif

  // A consumed HLT halts the queue whether it came from storage or the bypass.
  assign w_halt = (w_pop_q & is_hlt(w_head_insn)) | (w_pop_byp & is_hlt(in_f_insnbits));
  assign w_push = in_f_done & ~w_full & w_run & ~in_rob_mispredict & ~w_pop_byp & ~w_halt;

  always_comb begin
    out_d_valid    = w_q_valid;
    out_d_insnbits = '0;
    out_d_pc       = '0;
    if (w_q_valid) begin
      out_d_insnbits = w_head_insn;
      out_d_pc       = w_head_pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_byp) begin
      out_d_valid    = 1'b1;
      out_d_insnbits = in_f_insnbits;
      out_d_pc       = in_f_pc;
    end
`endif
  end

  assign out_f_full = w_full & w_run;
  assign out_count  = r_count;

  always_comb begin
    w_state_nxt = r_state;
    if (in_rob_mispredict) w_state_nxt = FQ_RUN;
    else if (w_halt)       w_state_nxt = FQ_HALTED;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) r_state <= FQ_RUN;
    else        r_state <= w_state_nxt;
  end

  // Flush and halt both empty the queue and drop any same-edge push/pop.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (in_rob_mispredict || w_halt) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_q) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop_q})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
